tbird_lamp_pixel_gen: RTL and testbench
=======================================

TBIRD_LAMP_PIXEL_GEN -- requirements
Module: tbird_lamp_pixel_gen

Interface
REQ-001 SHALL have parameter LAMP_TOP, default 200, first vCount row of the lamp band.
REQ-002 SHALL have parameter LAMP_BOT, default 279, last vCount row of the lamp band (inclusive).
REQ-003 SHALL have port clk, input, 1, 50 MHz system clock; the only clock; all flops on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port step_en, input, 1, one-clk-wide lamp-sequence advance strobe from the clock divider.
REQ-006 SHALL have ports left, right, hazard, input, 1 each, raw asynchronous switch levels.
REQ-007 SHALL have ports hCount, vCount, input, 10 each, current pixel column/row from the VGA timing stage.
REQ-008 SHALL have port rgb_lights, output, 3, pixel colour code: 100 red, 010 green, 001 blue, 000 black.
REQ-009 SHALL have port lamps, output, 6, lamp state {LC,LB,LA,RA,RB,RC}, 1 = lit.

Function
REQ-010 SHALL pass left, right and hazard each through a two-flop synchronizer; the FSM uses only synchronized values (sL, sR, sH).
REQ-011 SHALL implement FSM states IDLE, L1, L2, L3, R1, R2, R3, HAZ; state changes only on clk edges where step_en=1.
REQ-012 From IDLE on step: sH=1 or (sL=1 and sR=1) -> HAZ; else sL=1 -> L1; else sR=1 -> R1; else stay in IDLE.
REQ-013 HAZ on step -> IDLE unconditionally, so a held hazard blinks all lamps at half the step rate.
REQ-014 L1->L2->L3->IDLE and R1->R2->R3->IDLE on successive steps; releasing left/right mid-sequence does not abort it.
REQ-015 From any L*/R* state, sH=1 or (sL=1 and sR=1) at a step -> HAZ (abort takes priority over advance).
REQ-016 Lamp decode: IDLE none; L1 LA; L2 LA,LB; L3 LA,LB,LC; R1 RA; R2 RA,RB; R3 RA,RB,RC; HAZ all six.
REQ-017 lamps SHALL be registered, updating on the same edge as the state change, so it reflects the new state one clk after the step.
REQ-018 Lamp boxes occupy rows LAMP_TOP..LAMP_BOT in columns LC 16-95, LB 112-191, LA 208-287, RA 352-431, RB 448-527, RC 544-623, all inclusive.
REQ-019 Centre divider occupies columns 312-327 inside the lamp band rows.
REQ-020 Pixel colour: inside a lit lamp box 100; inside an unlit lamp box 001; inside the divider 010; everywhere else, including hCount>=640 or vCount>=480, 000.
REQ-021 rgb_lights SHALL be registered with one-clk latency from hCount/vCount, decoded against the lamps value registered on the same edge.
REQ-022 Column/row comparisons SHALL be unsigned 10-bit; boundaries are inclusive as listed, with no wrap-around handling needed.
REQ-023 step_en held high for multiple clks SHALL advance one state per clk; the block does not edge-detect step_en.

Reset
REQ-024 While reset=0: state IDLE, synchronizer flops 0, lamps=000000, rgb_lights=000, asynchronously.
REQ-025 After reset deasserts, the first state change SHALL occur at the first step_en after synchronized inputs are valid (>=2 clks).
REQ-026 Reset asserted mid-sequence SHALL return to IDLE immediately with no completion of the sequence.

Verification
REQ-027 left=1 held, 4 step_en pulses -> lamps 001000, 011000, 111000, 000000.
REQ-028 right=1 for 1 step then released, 3 more steps -> lamps 000100, 000110, 000111, 000000.
REQ-029 In state L2 (011000), assert hazard, step -> 111111; step -> 000000; step -> 111111.
REQ-030 left=right=1 from IDLE, step -> lamps 111111.
REQ-031 lamps=001000, vCount=240: hCount=250 -> rgb_lights 100 one clk later; hCount=150 -> 001; hCount=320 -> 010; hCount=300 -> 000; vCount=199 -> 000.
REQ-032 In state R3, assert reset=0 between clk edges -> lamps=000000 and rgb_lights=000 immediately; release, left=0/right=0, steps -> stays 000000.

Source files
------------

// File: rtl/tbird_lamp_pixel_gen.sv
// Thunderbird tail-lamp sequencer with a VGA pixel generator that draws the
// six lamp boxes and a centre divider inside a horizontal lamp band.
module tbird_lamp_pixel_gen #(
  parameter logic [9:0] LAMP_TOP = 10'd200,
  parameter logic [9:0] LAMP_BOT = 10'd279
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_en,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic [2:0] rgb_lights,
  output logic [5:0] lamps
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_e;

  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;
  localparam logic [2:0] RGB_BLACK = 3'b000;

  // Switch vectors are packed {hazard, right, left}.
  logic [2:0] sw_meta_q;
  logic [2:0] sw_sync_q;
  logic       s_l_s;
  logic       s_r_s;
  logic       s_h_s;
  logic       abort_s;
  state_e     state_q;
  state_e     state_d;
  logic [5:0] lamps_q;
  logic [5:0] lamps_d;
  logic [2:0] rgb_q;
  logic [2:0] rgb_d;

  function automatic logic [5:0] lamp_decode(input state_e st);
    logic [5:0] lm;
    case (st)
      IDLE:    lm = 6'b000000;
      L1:      lm = 6'b001000;
      L2:      lm = 6'b011000;
      L3:      lm = 6'b111000;
      R1:      lm = 6'b000100;
      R2:      lm = 6'b000110;
      R3:      lm = 6'b000111;
      HAZ:     lm = 6'b111111;
      default: lm = 6'b000000;
    endcase
    return lm;
  endfunction

  function automatic logic in_span(input logic [9:0] x, input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

  function automatic logic [2:0] box_colour(input logic lit);
    return lit ? RGB_RED : RGB_BLUE;
  endfunction

  function automatic logic [2:0] pixel_colour(input logic [9:0] h, input logic [9:0] v,
                                              input logic [5:0] lm);
    logic [2:0] c;
    logic       in_band;
    in_band = in_span(v, LAMP_TOP, LAMP_BOT) && (v < 10'd480) && (h < 10'd640);
    if (!in_band) begin
      c = RGB_BLACK;
    end else if (in_span(h, 10'd16, 10'd95)) begin
      c = box_colour(lm[5]);
    end else if (in_span(h, 10'd112, 10'd191)) begin
      c = box_colour(lm[4]);
    end else if (in_span(h, 10'd208, 10'd287)) begin
      c = box_colour(lm[3]);
    end else if (in_span(h, 10'd312, 10'd327)) begin
      c = RGB_GREEN;
    end else if (in_span(h, 10'd352, 10'd431)) begin
      c = box_colour(lm[2]);
    end else if (in_span(h, 10'd448, 10'd527)) begin
      c = box_colour(lm[1]);
    end else if (in_span(h, 10'd544, 10'd623)) begin
      c = box_colour(lm[0]);
    end else begin
      c = RGB_BLACK;
    end
    return c;
  endfunction

  assign s_l_s   = sw_sync_q[0];
  assign s_r_s   = sw_sync_q[1];
  assign s_h_s   = sw_sync_q[2];
  assign abort_s = s_h_s | (s_l_s & s_r_s);

  // Two-flop synchronizers for the raw switch levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= 3'b000;
      sw_sync_q <= 3'b000;
    end else begin
      sw_meta_q <= {hazard, right, left};
      sw_sync_q <= sw_meta_q;
    end
  end

  // Next-state logic; hazard or both-sides aborts any running sequence.
  always_comb begin
    state_d = state_q;
    if (step_en) begin
      case (state_q)
        IDLE: begin
          if (abort_s)    state_d = HAZ;
          else if (s_l_s) state_d = L1;
          else if (s_r_s) state_d = R1;
          else            state_d = IDLE;
        end
        L1:      state_d = abort_s ? HAZ : L2;
        L2:      state_d = abort_s ? HAZ : L3;
        L3:      state_d = abort_s ? HAZ : IDLE;
        R1:      state_d = abort_s ? HAZ : R2;
        R2:      state_d = abort_s ? HAZ : R3;
        R3:      state_d = abort_s ? HAZ : IDLE;
        HAZ:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Pixel colour uses the lamp value being registered on this same edge.
  always_comb begin
    lamps_d = lamp_decode(state_d);
    rgb_d   = pixel_colour(hCount, vCount, lamps_d);
  end

  // FSM state with registered lamp and pixel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lamps_q <= 6'b000000;
      rgb_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      lamps_q <= lamps_d;
      rgb_q   <= rgb_d;
    end
  end

  assign lamps      = lamps_q;
  assign rgb_lights = rgb_q;

endmodule

// File: tb/tb_tbird_lamp_pixel_gen.sv
// Self-checking bench for tbird_lamp_pixel_gen: directed scenarios plus a
// randomized run against a sequence/geometry reference model.
module tb_tbird_lamp_pixel_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       step_en;
  logic       left;
  logic       right;
  logic       hazard;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic [2:0] rgb_lights;
  logic [5:0] lamps;

  tbird_lamp_pixel_gen dut (
    .clk        (clk),
    .reset      (reset),
    .step_en    (step_en),
    .left       (left),
    .right      (right),
    .hazard     (hazard),
    .hCount     (hCount),
    .vCount     (vCount),
    .rgb_lights (rgb_lights),
    .lamps      (lamps)
  );

  always #10 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: sequence direction (0 none, 1 left, 2 right, 3 hazard)
  // and number of lamps lit so far, plus the two-stage switch delay line.
  localparam int BOX_LO [6] = '{16, 112, 208, 352, 448, 544};
  bit [2:0]   meta_m;
  bit [2:0]   sync_m;
  int         dir_m;
  int         pos_m;
  logic [5:0] lamps_m;
  logic [2:0] rgb_m;

  function automatic logic [5:0] lamp_pattern(input int dir, input int pos);
    case (dir)
      1:       return 6'(((1 << pos) - 1) << 3);
      2:       return 6'((7 << (3 - pos)) & 7);
      3:       return 6'h3f;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [2:0] pixel_ref(input int h, input int v, input logic [5:0] lm);
    if (h >= 640 || v >= 480 || v < 200 || v > 279) return 3'b000;
    for (int i = 0; i < 6; i++)
      if (h >= BOX_LO[i] && h <= BOX_LO[i] + 79) return lm[5-i] ? 3'b100 : 3'b001;
    if (h >= 312 && h <= 327) return 3'b010;
    return 3'b000;
  endfunction

  task automatic model_clear();
    meta_m = 3'b000; sync_m = 3'b000; dir_m = 0; pos_m = 0;
    lamps_m = 6'h00; rgb_m = 3'b000;
  endtask

  // One rising edge; the model consumes the inputs present at the edge.
  task automatic clk_edge();
    bit [2:0] s;
    bit       abort;
    @(posedge clk);
    if (!reset) begin
      model_clear();
    end else begin
      s = sync_m;
      abort = s[2] | (s[0] & s[1]);
      if (step_en) begin
        if (dir_m == 3) begin dir_m = 0; pos_m = 0; end
        else if (abort) begin dir_m = 3; pos_m = 0; end
        else if (dir_m == 0) begin
          if (s[0]) begin dir_m = 1; pos_m = 1; end
          else if (s[1]) begin dir_m = 2; pos_m = 1; end
        end
        else if (pos_m == 3) begin dir_m = 0; pos_m = 0; end
        else pos_m++;
      end
      sync_m = meta_m;
      meta_m = {hazard, right, left};
      lamps_m = lamp_pattern(dir_m, pos_m);
      rgb_m = pixel_ref(int'(hCount), int'(vCount), lamps_m);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; step_en = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0;
    hCount = 10'd0; vCount = 10'd0;
    model_clear();
    clk_edge(); clk_edge();
    reset = 1'b1;
    clk_edge();
  endtask

  task automatic settle_and_step();
    step_en = 1'b0; clk_edge(); clk_edge();
    step_en = 1'b1; clk_edge();
    step_en = 1'b0;
  endtask

  task automatic step_once();
    step_en = 1'b1; clk_edge();
    step_en = 1'b0; clk_edge();
  endtask

  task automatic test_reset();
    reset = 1'b0; step_en = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0;
    hCount = 10'd250; vCount = 10'd240;
    model_clear();
    #3;
    n_run++;
    if (lamps !== 6'h00) begin
      $display("FAIL reset_lamps got=%b exp=%b", lamps, 6'h00); n_fail++;
    end
    n_run++;
    if (rgb_lights !== 3'b000) begin
      $display("FAIL reset_rgb got=%b exp=%b", rgb_lights, 3'b000); n_fail++;
    end
    do_reset();
  endtask

  task automatic test_left_sequence();
    logic [5:0] exp_tab [4] = '{6'b001000, 6'b011000, 6'b111000, 6'b000000};
    do_reset();
    left = 1'b1;
    clk_edge(); clk_edge();
    for (int i = 0; i < 4; i++) begin
      step_once();
      n_run++;
      if (lamps !== exp_tab[i]) begin
        $display("FAIL left_seq_%0d got=%b exp=%b", i, lamps, exp_tab[i]); n_fail++;
      end
    end
    left = 1'b0;
  endtask

  task automatic test_right_release();
    logic [5:0] exp_tab [4] = '{6'b000100, 6'b000110, 6'b000111, 6'b000000};
    do_reset();
    right = 1'b1;
    settle_and_step();
    n_run++;
    if (lamps !== exp_tab[0]) begin
      $display("FAIL right_seq_0 got=%b exp=%b", lamps, exp_tab[0]); n_fail++;
    end
    right = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step_once();
      n_run++;
      if (lamps !== exp_tab[i]) begin
        $display("FAIL right_seq_%0d got=%b exp=%b", i, lamps, exp_tab[i]); n_fail++;
      end
    end
  endtask

  task automatic test_hazard_abort();
    logic [5:0] exp_tab [3] = '{6'b111111, 6'b000000, 6'b111111};
    do_reset();
    left = 1'b1;
    settle_and_step();
    step_once();
    n_run++;
    if (lamps !== 6'b011000) begin
      $display("FAIL haz_pre_l2 got=%b exp=%b", lamps, 6'b011000); n_fail++;
    end
    left = 1'b0; hazard = 1'b1;
    clk_edge(); clk_edge();
    for (int i = 0; i < 3; i++) begin
      step_once();
      n_run++;
      if (lamps !== exp_tab[i]) begin
        $display("FAIL haz_blink_%0d got=%b exp=%b", i, lamps, exp_tab[i]); n_fail++;
      end
    end
    hazard = 1'b0;
  endtask

  task automatic test_both_sides();
    do_reset();
    left = 1'b1; right = 1'b1;
    settle_and_step();
    n_run++;
    if (lamps !== 6'b111111) begin
      $display("FAIL both_sides got=%b exp=%b", lamps, 6'b111111); n_fail++;
    end
    left = 1'b0; right = 1'b0;
  endtask

  task automatic test_pixels();
    int tab [18][3] = '{
      '{250, 240, 3'b100}, '{150, 240, 3'b001}, '{320, 240, 3'b010}, '{300, 240, 3'b000},
      '{250, 199, 3'b000}, '{ 16, 240, 3'b001}, '{ 15, 240, 3'b000}, '{ 95, 240, 3'b001},
      '{ 96, 240, 3'b000}, '{287, 240, 3'b100}, '{288, 240, 3'b000}, '{312, 200, 3'b010},
      '{327, 279, 3'b010}, '{328, 240, 3'b000}, '{250, 280, 3'b000}, '{623, 240, 3'b001},
      '{640, 240, 3'b000}, '{1023, 1023, 3'b000}};
    do_reset();
    left = 1'b1;
    settle_and_step();
    left = 1'b0;
    for (int i = 0; i < 18; i++) begin
      hCount = 10'(tab[i][0]); vCount = 10'(tab[i][1]);
      clk_edge();
      hCount = 10'd0; vCount = 10'd0;
      n_run++;
      if (rgb_lights !== 3'(tab[i][2])) begin
        $display("FAIL pixel_h%0d_v%0d got=%b exp=%b", tab[i][0], tab[i][1],
                 rgb_lights, 3'(tab[i][2]));
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_sequence();
    do_reset();
    right = 1'b1;
    hCount = 10'd400; vCount = 10'd240;
    settle_and_step();
    step_once(); step_once();
    n_run++;
    if (lamps !== 6'b000111 || rgb_lights !== 3'b100) begin
      $display("FAIL mid_reset_pre got=%b/%b exp=%b/%b", lamps, rgb_lights, 6'b000111, 3'b100);
      n_fail++;
    end
    right = 1'b0;
    #4;
    reset = 1'b0;
    model_clear();
    #1;
    n_run++;
    if (lamps !== 6'h00 || rgb_lights !== 3'b000) begin
      $display("FAIL mid_reset_async got=%b/%b exp=%b/%b", lamps, rgb_lights, 6'h00, 3'b000);
      n_fail++;
    end
    clk_edge();
    reset = 1'b1;
    clk_edge(); clk_edge();
    for (int i = 0; i < 3; i++) begin
      step_once();
      n_run++;
      if (lamps !== 6'h00) begin
        $display("FAIL mid_reset_after_%0d got=%b exp=%b", i, lamps, 6'h00); n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_tab [5] = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b001000};
    do_reset();
    left = 1'b1;
    clk_edge(); clk_edge();
    step_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk_edge();
      n_run++;
      if (lamps !== exp_tab[i]) begin
        $display("FAIL b2b_step_%0d got=%b exp=%b", i, lamps, exp_tab[i]); n_fail++;
      end
    end
    step_en = 1'b0; left = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) left   = ~left;
      if ($urandom_range(0, 15) == 0) right  = ~right;
      if ($urandom_range(0, 31) == 0) hazard = ~hazard;
      step_en = ($urandom_range(0, 3) == 0);
      hCount = 10'($urandom_range(0, 1023));
      vCount = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                           : 10'($urandom_range(190, 290));
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        model_clear();
      end
      clk_edge();
      n_run++;
      if (lamps !== lamps_m || rgb_lights !== rgb_m) begin
        $display("FAIL random_c%0d got=%b/%b exp=%b/%b", c, lamps, rgb_lights, lamps_m, rgb_m);
        n_fail++;
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_left_sequence();
    test_right_release();
    test_hazard_abort();
    test_both_sides();
    test_pixels();
    test_reset_mid_sequence();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
